pc_fetch_sequencer: RTL and testbench

Multi-cycle fetch/advance controller for the program counter. It owns the PC register, issues fetch requests to instruction memory, and hands each fetched instruction to the datapath. After the datapath reports completion, it selects the next PC from the branch-resolution signals, using the sequential or the branch-target path. It sits between imem and the decode/execute datapath and replaces a free-running per-clock PC update.

---
 rtl/pc_seq_pkg.sv | 32 +++
 rtl/pc_next_calc.sv | 37 +++
 rtl/pc_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter fetch sequencer:
//   - pc_state_e    : FSM state encoding
//   - PC_W/INSTR_W  : datapath widths
//   - PC_INCR       : sequential PC step in bytes
//   - CNT_W/STAT_W  : fetch-timeout counter and statistics counter widths
//   - pc_is_aligned : word-alignment check for a candidate PC
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STAT_W  = 32;

    localparam logic [PC_W-1:0] PC_INCR = 64'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } pc_state_e;

    // Instructions are 32-bit words, so a legal PC has its two LSBs clear.
    function automatic logic pc_is_aligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Purely combinational next-PC selection.
//   CurrentPC    in  64  PC of the instruction that just completed
//   SignExtImm64 in  64  branch offset, already in bytes
//   Branch       in  1   conditional branch
//   ALUZero      in  1   ALU zero flag (condition for Branch)
//   Uncondbranch in  1   unconditional branch, overrides Branch/ALUZero
//   target       out 64  selected next PC (modulo 2^64)
//   taken        out 1   branch path selected
//   misaligned   out 1   target is not word aligned
// ---------------------------------------------------------------------------
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] CurrentPC,
    input  logic [PC_W-1:0] SignExtImm64,
    input  logic            Branch,
    input  logic            ALUZero,
    input  logic            Uncondbranch,
    output logic [PC_W-1:0] target,
    output logic            taken,
    output logic            misaligned
);

    // Branch decision, target adder (wraps silently) and alignment check
    always_comb begin
        taken = Uncondbranch | (Branch & ALUZero);
        if (taken) begin
            target = CurrentPC + SignExtImm64;
        end else begin
            target = CurrentPC + PC_INCR;
        end
        misaligned = ~pc_is_aligned(target);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Multi-cycle fetch/advance controller owning the architectural PC.
// Sequence per instruction: FETCH (request until imem_ack) -> EXEC (wait
// for exec_done) -> next PC, then FETCH again or HALTED. A fetch that
// waits MEM_TIMEOUT cycles, or a misaligned next PC, ends in FAULT.
// HALTED and FAULT are left only through resetl.
//
// Parameters:
//   RESET_PC     PC loaded on reset
//   MEM_TIMEOUT  FETCH cycles without imem_ack before fault (1..255)
//
// Ports:
//   CLK           in  1   system clock, rising edge
//   resetl        in  1   asynchronous active-low reset
//   imem_req      out 1   fetch request, held until ack
//   imem_addr     out 64  fetch address (== CurrentPC)
//   imem_ack      in  1   imem_data valid this cycle
//   imem_data     in  32  fetched instruction word
//   instr         out 32  latched instruction
//   instr_valid   out 1   one-cycle pulse when instr is new
//   exec_done     in  1   datapath finished; branch inputs valid
//   SignExtImm64  in  64  branch offset in bytes
//   Branch        in  1   conditional branch
//   ALUZero       in  1   ALU zero flag
//   Uncondbranch  in  1   unconditional branch
//   halt          in  1   stop after this instruction (with exec_done)
//   CurrentPC     out 64  architectural PC
//   busy          out 1   high in FETCH or EXEC
//   fault         out 1   sticky fault (timeout or misaligned target)
//
// Optional build macro PC_BRANCH_STATS_EN adds saturating counters:
//   retired_count out 32  successfully completed instructions
//   taken_count   out 32  completed instructions whose branch was taken
// ---------------------------------------------------------------------------
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 64'h0,
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               resetl,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic [PC_W-1:0]    SignExtImm64,
    input  logic               Branch,
    input  logic               ALUZero,
    input  logic               Uncondbranch,
    input  logic               halt,
    output logic [PC_W-1:0]    CurrentPC,
    output logic               busy,
    output logic               fault
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  retired_count,
    output logic [STAT_W-1:0]  taken_count
`endif
);

    // Last counter value that may still see an ack before the fetch faults.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    pc_state_e          state_r;
    pc_state_e          state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic               instr_valid_r;
    logic               imem_req_r;
    logic               busy_r;
    logic               fault_r;

    logic [PC_W-1:0]    target_s;
    logic               misaligned_s;
    logic               ack_s;
    logic               done_s;
    logic               complete_s;
`ifdef PC_BRANCH_STATS_EN
    logic               taken_s;
`endif

    pc_next_calc u_next (
        .CurrentPC    (pc_r),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .target       (target_s),
`ifdef PC_BRANCH_STATS_EN
        .taken        (taken_s),
`else
        .taken        (),
`endif
        .misaligned   (misaligned_s)
    );

    // Qualify handshakes by state so stray ack/exec_done are ignored
    always_comb begin
        ack_s      = (state_r == ST_FETCH) & imem_ack;
        done_s     = (state_r == ST_EXEC) & exec_done;
        complete_s = done_s & ~misaligned_s;
    end

    // Next-state logic; ack has priority over timeout in FETCH
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_s = ST_EXEC;
                end else if (cnt_r >= TMO_LAST) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!exec_done) begin
                    state_s = ST_EXEC;
                end else if (misaligned_s) begin
                    state_s = ST_FAULT;
                end else if (halt) begin
                    state_s = ST_HALTED;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s = ST_FAULT;
            end
        endcase
    end

    // State register and state-decoded registered outputs
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_r    <= ST_IDLE;
            imem_req_r <= 1'b0;
            busy_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            imem_req_r <= (state_s == ST_FETCH);
            busy_r     <= (state_s == ST_FETCH) | (state_s == ST_EXEC);
            fault_r    <= (state_s == ST_FAULT);
        end
    end

    // Fetch wait counter: counts unacknowledged FETCH cycles
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_FETCH) && !imem_ack) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Instruction latch and its one-cycle valid pulse
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            instr_r       <= {INSTR_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            instr_valid_r <= ack_s;
            if (ack_s) begin
                instr_r <= imem_data;
            end
        end
    end

    // Architectural PC: advances only on a non-faulting completion
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            pc_r <= RESET_PC;
        end else if (complete_s) begin
            pc_r <= target_s;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = 32'hFFFF_FFFF;
    logic [STAT_W-1:0] retired_r;
    logic [STAT_W-1:0] taken_cnt_r;

    // Saturating retire / taken-branch counters
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            retired_r   <= {STAT_W{1'b0}};
            taken_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (complete_s && (retired_r != STAT_MAX)) begin
                retired_r <= retired_r + 32'd1;
            end
            if (complete_s && taken_s && (taken_cnt_r != STAT_MAX)) begin
                taken_cnt_r <= taken_cnt_r + 32'd1;
            end
        end
    end

    assign retired_count = retired_r;
    assign taken_count   = taken_cnt_r;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign CurrentPC   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Transaction-level bench: each instruction is driven as fetch (with a
// chosen memory latency) plus execute (with chosen branch inputs); the
// expected PC / fault / halt outcome is computed from the instruction's
// rules and compared with the DUT. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam int          MEM_TO = 4;

    logic        CLK          = 1'b0;
    logic        resetl       = 1'b0;
    logic        imem_ack     = 1'b0;
    logic [31:0] imem_data    = 32'h0;
    logic        exec_done    = 1'b0;
    logic [63:0] SignExtImm64 = 64'h0;
    logic        Branch       = 1'b0;
    logic        ALUZero      = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        halt         = 1'b0;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [63:0] CurrentPC;
    logic        busy;
    logic        fault;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] retired_count;
    logic [31:0] taken_count;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [63:0]     m_pc;
    bit              m_dead;
    bit              m_fault;
    longint unsigned m_ret;
    longint unsigned m_tkn;

    pc_fetch_sequencer #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (MEM_TO)
    ) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .halt         (halt),
        .CurrentPC    (CurrentPC),
        .busy         (busy),
        .fault        (fault)
`ifdef PC_BRANCH_STATS_EN
        ,
        .retired_count(retired_count),
        .taken_count  (taken_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stats();
`ifdef PC_BRANCH_STATS_EN
        chk("retired_count", {32'h0, retired_count}, (m_ret > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ret);
        chk("taken_count", {32'h0, taken_count}, (m_tkn > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tkn);
`endif
    endtask

    // inputs that must be ignored outside EXEC
    task automatic drive_noise();
        exec_done    = 1'($urandom_range(0, 1));
        Branch       = 1'($urandom_range(0, 1));
        ALUZero      = 1'($urandom_range(0, 1));
        Uncondbranch = 1'($urandom_range(0, 1));
        halt         = 1'($urandom_range(0, 1));
        SignExtImm64 = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] rnd_imm();
        logic [13:0] r;
        logic [63:0] v;
        r = 14'($urandom);
        v = {{50{r[13]}}, r};
        if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    // Assert reset between clock edges, check outputs before the next edge,
    // release and land on the first FETCH cycle.
    task automatic do_reset(input bit late_ack);
        @(negedge CLK);
        #2;
        resetl    = 1'b0;
        imem_ack  = late_ack;
        exec_done = 1'b0;
        halt      = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", CurrentPC, RST_PC);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_ivalid", instr_valid, 1'b0);
        chk("rst_instr", instr, 64'h0);
        m_pc = RST_PC; m_dead = 0; m_fault = 0; m_ret = 0; m_tkn = 0;
        check_stats();
        @(negedge CLK);
        resetl = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0;
        chk("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, RST_PC);
        chk("rel_ivalid", instr_valid, 1'b0);
        chk("rel_busy", busy, 1'b1);
    endtask

    // One instruction: lat unacknowledged fetch cycles, ack, dly idle EXEC
    // cycles, then exec_done with the given branch inputs.
    task automatic run_instr(input int lat, input int dly, input bit br, input bit z,
                             input bit ub, input logic [63:0] imm, input bit hlt,
                             input logic [31:0] data);
        logic [63:0] tgt;
        bit tk;
        if (m_dead) return;
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int k = 0; k < lat; k++) begin
            imem_ack = 1'b0;
            drive_noise();
            @(negedge CLK);
            if (k + 1 >= MEM_TO) begin
                exec_done = 1'b0;
                halt      = 1'b0;
                chk("tmo_fault", fault, 1'b1);
                chk("tmo_req", imem_req, 1'b0);
                chk("tmo_busy", busy, 1'b0);
                chk("tmo_pc", CurrentPC, m_pc);
                chk("tmo_ivalid", instr_valid, 1'b0);
                m_dead = 1; m_fault = 1;
                return;
            end
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, m_pc);
            chk("stall_ivalid", instr_valid, 1'b0);
            chk("stall_fault", fault, 1'b0);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        drive_noise();
        @(negedge CLK);
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        chk("ack_ivalid", instr_valid, 1'b1);
        chk("ack_instr", instr, data);
        chk("ack_req", imem_req, 1'b0);
        chk("ack_busy", busy, 1'b1);
        for (int d = 0; d < dly; d++) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = $urandom;
            exec_done = 1'b0;
            halt      = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("wait_ivalid", instr_valid, 1'b0);
            chk("wait_instr", instr, data);
            chk("wait_req", imem_req, 1'b0);
            chk("wait_pc", CurrentPC, m_pc);
        end
        imem_ack     = 1'b0;
        exec_done    = 1'b1;
        Branch       = br;
        ALUZero      = z;
        Uncondbranch = ub;
        SignExtImm64 = imm;
        halt         = hlt;
        @(negedge CLK);
        exec_done = 1'b0;
        halt      = 1'b0;
        tk  = ub | (br & z);
        tgt = m_pc + (tk ? imm : 64'd4);
        if (tgt % 4 != 0) begin
            chk("mis_fault", fault, 1'b1);
            chk("mis_pc", CurrentPC, m_pc);
            chk("mis_req", imem_req, 1'b0);
            chk("mis_busy", busy, 1'b0);
            m_dead = 1; m_fault = 1;
        end else begin
            m_pc = tgt;
            m_ret++;
            if (tk) m_tkn++;
            chk("exec_pc", CurrentPC, tgt);
            chk("exec_fault", fault, 1'b0);
            chk("exec_ivalid", instr_valid, 1'b0);
            if (hlt) begin
                chk("halt_busy", busy, 1'b0);
                chk("halt_req", imem_req, 1'b0);
                m_dead = 1;
            end else begin
                chk("next_req", imem_req, 1'b1);
                chk("next_busy", busy, 1'b1);
                chk("next_addr", imem_addr, tgt);
            end
        end
    endtask

    // Terminal states must hold against any input activity
    task automatic hold_dead();
        for (int i = 0; i < 4; i++) begin
            drive_noise();
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = $urandom;
            @(negedge CLK);
            chk("dead_pc", CurrentPC, m_pc);
            chk("dead_req", imem_req, 1'b0);
            chk("dead_busy", busy, 1'b0);
            chk("dead_fault", fault, m_fault);
            chk("dead_ivalid", instr_valid, 1'b0);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        halt      = 1'b0;
        check_stats();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        do_reset(1'b0);
        // sequential fetch from RESET_PC
        run_instr(0, 1, 0, 0, 0, 64'h0, 0, 32'hA000_0001);
        run_instr(0, 1, 0, 0, 0, 64'h0, 0, 32'hA000_0002);
        run_instr(0, 1, 0, 0, 0, 64'h0, 0, 32'hA000_0003);
        chk("seq_pc", CurrentPC, 64'h10C);
        // branch decisions
        run_instr(0, 0, 0, 0, 1, 64'hF4, 0, 32'hB000_0000);
        chk("jump_pc", CurrentPC, 64'h200);
        run_instr(1, 1, 1, 0, 0, 64'h40, 0, 32'hB000_0001);
        chk("br_nt_pc", CurrentPC, 64'h204);
        run_instr(0, 1, 1, 1, 0, 64'h40, 0, 32'hB000_0002);
        chk("br_t_pc", CurrentPC, 64'h244);
        run_instr(2, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 32'hB000_0003);
        chk("ub_pc", CurrentPC, 64'h23C);
        // stalled but acknowledged fetch, then halt
        run_instr(3, 1, 0, 0, 1, 64'hC4, 0, 32'hC000_0000);
        run_instr(0, 0, 0, 0, 1, 64'h100, 0, 32'hC000_0001);
        run_instr(0, 1, 0, 0, 0, 64'h0, 1, 32'hC000_0002);
        chk("halt_pc", CurrentPC, 64'h404);
        chk("halt_busy_c", busy, 1'b0);
        hold_dead();

        // fetch timeout
        do_reset(1'b0);
        run_instr(0, 0, 0, 0, 1, 64'h100, 0, 32'hD000_0000);
        run_instr(6, 0, 0, 0, 0, 64'h0, 0, 32'hD000_0001);
        chk("tmo_fault_c", fault, 1'b1);
        chk("tmo_pc_c", CurrentPC, 64'h200);
        hold_dead();

        // misaligned branch target
        do_reset(1'b0);
        run_instr(0, 0, 0, 0, 1, 64'h200, 0, 32'hE000_0000);
        run_instr(0, 1, 0, 0, 1, 64'h6, 0, 32'hE000_0001);
        chk("mis_fault_c", fault, 1'b1);
        chk("mis_pc_c", CurrentPC, 64'h300);
        hold_dead();

        // wrap-around through 2^64
        do_reset(1'b0);
        run_instr(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FEFC, 0, 32'hF000_0000);
        chk("wrap_pre", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(0, 1, 0, 0, 0, 64'h0, 0, 32'hF000_0001);
        chk("wrap_pc", CurrentPC, 64'h0);
        chk("wrap_fault", fault, 1'b0);
        check_stats();
        // async reset in the middle of a fetch, with a late ack
        run_instr(0, 0, 0, 0, 1, 64'h200, 0, 32'hF000_0002);
        do_reset(1'b1);

        // randomized instruction streams
        repeat (40) begin
            n = 0;
            while (!m_dead && n < 12) begin
                run_instr(($urandom_range(0, 19) == 0) ? 5 : int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0),
                          rnd_imm(),
                          ($urandom_range(0, 14) == 0),
                          $urandom);
                n++;
            end
            if (m_dead) hold_dead();
            else check_stats();
            do_reset(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
